// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// Holds the FSM state encodings, data width and default baud divider.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int CLK_DIV_DEFAULT = 5208;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: the head entry is always visible on o_rd_data.
// A write into a full FIFO succeeds only when a read happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;

  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_rd    = i_rd_en & ~w_empty;
  assign w_wr    = i_wr_en & (~w_full | w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A dropped byte leaves contents and pointers untouched.
      r_overrun <= i_wr_en & w_full & ~w_rd;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = ~w_empty;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: line synchronizer, mid-bit sampling FSM and receive FIFO.
// Good frames are pushed one cycle after the stop-bit sample; bad stop bits pulse frame_err.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rs232_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync_prev;
  logic [1:0]           r_state;
  logic [CW-1:0]        r_baud;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_push;
  logic                 r_frame_err;

  logic w_start_edge;

  assign w_start_edge = ~r_sync2 & r_sync_prev;

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rs232_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_baud  <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_baud == HALF_M1) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_baud == FULL_M1) begin
            r_baud             <= '0;
            r_shift[r_bit_idx] <= r_sync2;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          if (r_baud == FULL_M1) begin
            r_baud      <= '0;
            r_state     <= ST_IDLE;
            r_push      <= r_sync2;
            r_frame_err <= ~r_sync2;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
      endcase
    end
  end

  // r_shift stays stable until the next frame's first data sample, well after the push.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_push),
    .i_wr_data (r_shift),
    .i_rd_en   (rx_ready),
    .o_rd_data (rx_data),
    .o_valid   (rx_valid),
    .o_count   (fifo_count),
    .o_overrun (overrun)
  );

  assign busy      = (r_state != ST_IDLE);
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven bit by bit, outputs checked every cycle
// against a queue-based model of when each byte lands in the FIFO.
module tb_uart_rx_ctrl;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int LAT     = 2 + CLK_DIV/2 + 9*CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  uart_rx_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs232_rx   (rs232_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] q[$];
  int         pend_cycle = -1;
  logic [7:0] pend_byte = 8'h00;
  bit         pend_good = 1'b0;
  int         fe_cycle = -1;
  int         bs = 0;
  int         be = 0;
  int         c0 = 0;
  bit         rand_ready = 1'b0;

  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         rise_count = 0;
  logic [7:0] rise_data = 8'h00;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  bit         prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: the FIFO is a queue; a good frame lands LAT edges after its start bit is registered.
  initial begin
    bit         ready_e;
    bit         exp_ov;
    bit         exp_fe;
    bit         exp_busy;
    forever begin
      @(posedge clk);
      cyc++;
      ready_e = rx_ready;
      #1;
      if (rst) begin
        q.delete();
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);
      end else begin
        if (ready_e && q.size() > 0) void'(q.pop_front());
        exp_ov = 1'b0;
        if (cyc == pend_cycle && pend_good) begin
          if (q.size() < DEPTH) q.push_back(pend_byte);
          else exp_ov = 1'b1;
        end
        exp_fe   = (cyc == fe_cycle);
        exp_busy = (cyc >= bs) && (cyc < be);
        chk("rx_valid", int'(rx_valid), int'(q.size() > 0));
        chk("fifo_count", int'(fifo_count), q.size());
        if (q.size() > 0) chk("rx_data", int'(rx_data), int'(q[0]));
        chk("busy", int'(busy), int'(exp_busy));
        chk("frame_err", int'(frame_err), int'(exp_fe));
        chk("overrun", int'(overrun), int'(exp_ov));
      end
      if (rx_valid && !prev_valid) begin
        rise_cnt++;
        rise_cyc   = cyc;
        rise_data  = rx_data;
        rise_count = int'(fifo_count);
      end
      prev_valid = rx_valid;
      fe_cnt += int'(frame_err);
      ov_cnt += int'(overrun);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_stats();
    rise_cnt = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int abort_at,
                            input bit ready_at_push);
    logic [9:0] bits;
    int         n;
    bits       = {good, b, 1'b0};
    c0         = cyc + 1;
    pend_cycle = c0 + LAT;
    pend_byte  = b;
    pend_good  = good;
    fe_cycle   = good ? -1 : c0 + LAT - 1;
    bs         = c0 + 2;
    be         = c0 + LAT - 1;
    $display("frame data=%02h stop=%0b start_cycle=%0d", b, good, c0);
    for (int i = 0; i < 10; i++) begin
      rs232_rx = bits[i];
      for (int t = 0; t < CLK_DIV; t++) begin
        n = i*CLK_DIV + t;
        if (abort_at > 0 && n == abort_at) begin
          rst        = 1'b1;
          rs232_rx   = 1'b1;
          pend_cycle = -1;
          fe_cycle   = -1;
          be         = 0;
          repeat (2) tick();
          rst = 1'b0;
          tick();
          return;
        end
        if (ready_at_push && cyc == c0 + LAT - 1) rx_ready = 1'b1;
        else if (ready_at_push && cyc == c0 + LAT) rx_ready = 1'b0;
        tick();
      end
    end
    rs232_rx = 1'b1;
    if (!good) repeat (CLK_DIV) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single good byte, consumer always ready: latency and 0->1->0 occupancy.
    rx_ready = 1'b1;
    clear_stats();
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    chk("a5_rises", rise_cnt, 1);
    chk("a5_latency", rise_cyc - c0, 155);
    chk("a5_data", int'(rise_data), 8'hA5);
    chk("a5_count_at_rise", rise_count, 1);
    chk("a5_count_after", int'(fifo_count), 0);

    // Stop bit forced low.
    clear_stats();
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    chk("3c_ferr_pulses", fe_cnt, 1);
    chk("3c_rises", rise_cnt, 0);

    // Short low glitch rejected in START.
    clear_stats();
    c0 = cyc + 1;
    bs = c0 + 2;
    be = c0 + CLK_DIV/2 + 2;
    rs232_rx = 1'b0;
    repeat (4) tick();
    rs232_rx = 1'b1;
    repeat (2*CLK_DIV) tick();
    chk("glitch_ferr", fe_cnt, 0);
    chk("glitch_rises", rise_cnt, 0);
    chk("glitch_busy", int'(busy), 0);

    // Fill past capacity with the consumer stalled, then drain in order.
    rx_ready = 1'b0;
    clear_stats();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
    chk("fill_count", int'(fifo_count), 4);
    chk("fill_overruns", ov_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", int'(rx_valid), 1);
      chk("drain_data", int'(rx_data), i);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("drain_count", int'(fifo_count), 0);

    // Full FIFO with a pop on the push cycle: no overrun.
    clear_stats();
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), 1'b1, 0, 1'b0);
    send_frame(8'h15, 1'b1, 0, 1'b1);
    chk("full_pop_overruns", ov_cnt, 0);
    chk("full_pop_count", int'(fifo_count), 4);
    chk("full_pop_head", int'(rx_data), 8'h12);
    rx_ready = 1'b1;
    repeat (6) tick();

    // Reset at the data bit 3 sample, then a clean frame.
    clear_stats();
    send_frame(8'hC3, 1'b1, 4*CLK_DIV + CLK_DIV/2 + 2, 1'b0);
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    chk("abort_rises", rise_cnt, 1);
    chk("abort_data", int'(rise_data), 8'h5A);
    chk("abort_ferr", fe_cnt, 0);
    chk("abort_ovr", ov_cnt, 0);

    // Random frames, random stop bits, random consumer back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 0, 1'b0);
      repeat ($urandom_range(0, 10)) tick();
    end
    rand_ready = 1'b0;
    rx_ready   = 1'b1;
    repeat (10) tick();
    chk("final_count", int'(fifo_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
